cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TIMEOUT_CYCLES, 255: refill watchdog limit in cycles, used only when REFILL_TIMEOUT_EN is defined.
- BEAT_W, 32: memory beat width; fixed at 32.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpuReq  in  1  CPU read access request.
- cpuAddr  in  32  CPU byte address.
- cpuReady  out  1  one-cycle pulse when the access completes.
- cacheAddress  out  32  latched address driven to the cache.
- DMread  out  1  cache lookup strobe.
- cacheHit  in  1  cache hit, combinational from the cache.
- DMWrite  out  1  block-write strobe to the cache.
- blockData  out  512  assembled refill block.
- tag  out  25  refill tag, equal to latched address [31:7].
- valid  out  1  valid bit written with the block.
- memReq  out  1  memory burst request.
- memAddress  out  32  block-aligned burst address.
- memAck  in  1  memory accepts the request.
- memValid  in  1  beat valid.
- memData  in  32  beat data.
- memError  out  1  one-cycle refill-abort pulse.

Function
REQ-003 The FSM SHALL have states IDLE, LOOKUP, REQ, FILL, WRITE and DONE.
REQ-004 IDLE: when cpuReq=1, the block SHALL latch cpuAddr into addrQ and go to LOOKUP; cpuReq outside IDLE SHALL be ignored.
REQ-005 LOOKUP: the block SHALL drive DMread=1; cacheHit=1 SHALL go to DONE; cacheHit=0 SHALL go to REQ.
REQ-006 REQ: the block SHALL drive memReq=1 and memAddress={addrQ[31:6],6'b0}, and SHALL hold them until a cycle with memAck=1, then go to FILL.
REQ-007 FILL: each memValid=1 cycle SHALL store memData into blockData[32*beatCnt +: 32] and increment the 4-bit beatCnt; the beat with beatCnt=15 SHALL cause the move to WRITE.
REQ-008 memValid outside FILL SHALL be ignored; idle cycles between beats SHALL NOT advance beatCnt.
REQ-009 WRITE: for exactly one cycle the block SHALL drive DMWrite=1, valid=1, tag=addrQ[31:7] and a stable blockData, then go to LOOKUP (replay).
REQ-010 A replay that misses SHALL re-run the refill with no special casing.
REQ-011 DONE: the block SHALL drive cpuReady=1 for one cycle, then go to IDLE.
REQ-012 Hit latency SHALL be: request sampled at edge k, cpuReady high in the cycle after edge k+2.
REQ-013 cacheAddress SHALL always equal addrQ.
REQ-014 DMread, DMWrite, memReq, cpuReady and memError SHALL be registered Moore outputs of the state.
REQ-015 beatCnt SHALL clear on entry to FILL.

Reset
REQ-016 reset=1 SHALL asynchronously force IDLE, and clear addrQ, beatCnt, blockData, tag, valid and every strobe to 0.
REQ-017 Reset during REQ or FILL SHALL discard partial beats; the next request SHALL start at beat 0.

Configuration
REQ-018 With REFILL_TIMEOUT_EN defined:
- a counter SHALL clear on entry to REQ and count every cycle in REQ and FILL.
- on reaching TIMEOUT_CYCLES, the block SHALL pulse memError and cpuReady together for one cycle, go to IDLE and issue no DMWrite.
REQ-019 Without REFILL_TIMEOUT_EN, memError SHALL be tied to 0, no counter SHALL exist, and the refill SHALL wait indefinitely.

Structure
REQ-020 Package cache_pkg SHALL hold:
- BLOCK_BITS=512, WORD_BITS=32, BEATS=16, TAG_BITS=25, OFFSET_BITS=6.
- the refill_state_t state encoding.
REQ-021 Sub-module refill_buffer SHALL hold the 16x32 beat storage and beatCnt, with write-enable, clear and a 512-bit output.

Verification
REQ-022 Reset, then cpuReq with cpuAddr=0x0000_1040 and cacheHit=1 -> one DMread cycle, cpuReady pulse 2 cycles after LOOKUP, memReq never asserted.
REQ-023 cpuAddr=0x1234_5678, miss, memData=i+1 for beats i=0..15:
- memAddress=0x1234_5640.
- DMWrite one cycle with tag=0x02468AC and blockData[32i+:32]=i+1.
- replay hit, then cpuReady.
REQ-024 Refill with 3 idle cycles between every beat -> identical blockData; DMWrite one cycle after beat 15.
REQ-025 reset pulse after 7 beats -> all outputs 0 and state IDLE; the next miss refills all 16 beats correctly.
REQ-026 cpuReq toggled during FILL with a different address -> ignored; tag still from the original address.
REQ-027 REFILL_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, memAck held 0 -> memError and cpuReady pulse together after 8 REQ cycles; no DMWrite.

Source files
------------

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared constants and the refill FSM encoding for the cache refill controller.
package cache_pkg;
  localparam int BLOCK_BITS  = 512;
  localparam int WORD_BITS   = 32;
  localparam int BEATS       = 16;
  localparam int TAG_BITS    = 25;
  localparam int OFFSET_BITS = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REQ,
    FILL,
    WRITE,
    DONE
  } refill_state_t;
endpackage

// File: rtl/cache_refill_ctrl_buffer.sv
// Refill beat storage: 16 x 32-bit beats assembled into one 512-bit block.
// Beat 0 lands in bits [31:0]; beatCnt points at the next slot to fill.
module refill_buffer
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  we,
  input  logic [WORD_BITS-1:0]  din,
  output logic [3:0]            beatCnt,
  output logic [BLOCK_BITS-1:0] dout
);
  logic [BEATS-1:0][WORD_BITS-1:0] beats;

  // Store one beat per write enable; clear only rewinds the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beats   <= '0;
      beatCnt <= '0;
    end else if (clr) begin
      beatCnt <= '0;
    end else if (we) begin
      beats[beatCnt] <= din;
      beatCnt        <= beatCnt + 4'd1;
    end
  end

  assign dout = beats;
endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: lookup, burst refill of a 64-byte block, write
// into the cache, then replay the lookup.
// Optional watchdog: define REFILL_TIMEOUT_EN to abort a stalled refill after
// TIMEOUT_CYCLES cycles spent in REQ/FILL (memError + cpuReady pulse).
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int BEAT_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuReq,
  input  logic [31:0]           cpuAddr,
  output logic                  cpuReady,
  output logic [31:0]           cacheAddress,
  output logic                  DMread,
  input  logic                  cacheHit,
  output logic                  DMWrite,
  output logic [BLOCK_BITS-1:0] blockData,
  output logic [TAG_BITS-1:0]   tag,
  output logic                  valid,
  output logic                  memReq,
  output logic [31:0]           memAddress,
  input  logic                  memAck,
  input  logic                  memValid,
  input  logic [BEAT_W-1:0]     memData,
  output logic                  memError
);
  refill_state_t state, nextState;
  logic [31:0]   addrQ;
  logic [3:0]    beatCnt;
  logic          timeout;
  logic          bufClr, bufWe;

  assign bufClr = (state == REQ) && (nextState == FILL);
  assign bufWe  = (state == FILL) && memValid;

  refill_buffer uBuf (
    .clk     (clk),
    .reset   (reset),
    .clr     (bufClr),
    .we      (bufWe),
    .din     (memData),
    .beatCnt (beatCnt),
    .dout    (blockData)
  );

`ifdef REFILL_TIMEOUT_EN
  logic [15:0] toCnt;

  assign timeout = ((state == REQ) || (state == FILL)) &&
                   (toCnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: restart on entry to REQ, count every REQ/FILL cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      toCnt <= '0;
    else if ((state != REQ) && (nextState == REQ))
      toCnt <= '0;
    else if ((state == REQ) || (state == FILL))
      toCnt <= toCnt + 16'd1;
  end

  // Abort strobe rides alongside the cpuReady that ends the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) memError <= 1'b0;
    else       memError <= timeout;
  end
`else
  assign timeout  = 1'b0;
  assign memError = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic; a watchdog abort overrides the normal refill flow.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (cpuReq) nextState = LOOKUP;
      LOOKUP:  nextState = cacheHit ? DONE : REQ;
      REQ:     if (memAck) nextState = FILL;
      FILL:    if (memValid && (beatCnt == 4'd15)) nextState = WRITE;
      WRITE:   nextState = LOOKUP;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (timeout) nextState = IDLE;
  end

  // Address latch: only a request seen in IDLE is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        addrQ <= '0;
    else if ((state == IDLE) && cpuReq) addrQ <= cpuAddr;
  end

  // Registered strobes; cpuReady trails DONE by one cycle to give the
  // three-edge hit latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DMread   <= 1'b0;
      DMWrite  <= 1'b0;
      memReq   <= 1'b0;
      valid    <= 1'b0;
      cpuReady <= 1'b0;
      tag      <= '0;
    end else begin
      DMread   <= (nextState == LOOKUP);
      DMWrite  <= (nextState == WRITE);
      memReq   <= (nextState == REQ);
      valid    <= (nextState == WRITE);
      cpuReady <= (state == DONE) || timeout;
      if (nextState == WRITE) tag <= addrQ[31:7];
    end
  end

  assign cacheAddress = addrQ;
  assign memAddress   = memReq ? {addrQ[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: hit path, refills with and without
// beat gaps, reset mid-refill, ignored requests, optional watchdog abort.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

`ifdef REFILL_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic         clk = 1'b0, reset = 1'b1;
  logic         cpuReq = 1'b0, cacheHit = 1'b0, memAck = 1'b0, memValid = 1'b0;
  logic [31:0]  cpuAddr = '0, memData = '0;
  logic         cpuReady, DMread, DMWrite, valid, memReq, memError;
  logic [31:0]  cacheAddress, memAddress;
  logic [511:0] blockData;
  logic [24:0]  tag;

  int total = 0, bad = 0;
  int dmReadCnt = 0, dmWriteCnt = 0, memReqCnt = 0;

  cache_refill_ctrl #(.TIMEOUT_CYCLES(TO), .BEAT_W(32)) dut (
    .clk(clk), .reset(reset), .cpuReq(cpuReq), .cpuAddr(cpuAddr),
    .cpuReady(cpuReady), .cacheAddress(cacheAddress), .DMread(DMread),
    .cacheHit(cacheHit), .DMWrite(DMWrite), .blockData(blockData),
    .tag(tag), .valid(valid), .memReq(memReq), .memAddress(memAddress),
    .memAck(memAck), .memValid(memValid), .memData(memData),
    .memError(memError)
  );

  always #5 clk = ~clk;

  // Strobe cycle counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (DMread)  dmReadCnt  <= dmReadCnt + 1;
    if (DMWrite) dmWriteCnt <= dmWriteCnt + 1;
    if (memReq)  memReqCnt  <= memReqCnt + 1;
  end

  task automatic chk(input string tg, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tg, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss, burst refill with `gap` idle cycles before each beat, replay hit.
  task automatic refill(input logic [31:0] addr, input logic [31:0] base,
                        input int gap, input bit poke);
    logic [511:0] expBlk;
    int w0;
    for (int i = 0; i < 16; i++) expBlk[32*i +: 32] = base + 32'(i);
    w0 = dmWriteCnt;
    cpuAddr = addr; cpuReq = 1'b1; cacheHit = 1'b0;
    step();
    cpuReq = 1'b0;
    step();
    chk("memReq", memReq, 1'b1);
    chk("memAddress", memAddress, {addr[31:6], 6'b0});
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) step();
      memValid = 1'b1; memData = base + 32'(i);
      if (poke && i == 5) begin cpuReq = 1'b1; cpuAddr = 32'hABCD_0000; end
      step();
      memValid = 1'b0; cpuReq = 1'b0;
      if (poke && i == 5) chk("pokeAddr", cacheAddress, addr);
    end
    chk("dmWrite", DMWrite, 1'b1);
    chk("valid", valid, 1'b1);
    chk("tag", tag, addr[31:7]);
    chk("blockData", blockData, expBlk);
    cacheHit = 1'b1;
    step();
    chk("dmWriteOff", DMWrite, 1'b0);
    chk("replayRead", DMread, 1'b1);
    step();
    step();
    chk("replayReady", cpuReady, 1'b1);
    chk("dmWriteCycles", dmWriteCnt - w0, 1);
    cacheHit = 1'b0;
    step();
    chk("readyOff", cpuReady, 1'b0);
  endtask

  initial begin
    int r0, m0;
    step(); step();
    chk("rstReady", cpuReady, 1'b0);
    chk("rstAddr", cacheAddress, 32'h0);
    chk("rstBlock", blockData, 512'h0);
    chk("rstMemReq", memReq, 1'b0);
    chk("rstErr", memError, 1'b0);
    reset = 1'b0;
    step();

    // Hit: request at edge k, cpuReady in the cycle after k+2.
    r0 = dmReadCnt; m0 = memReqCnt;
    cpuAddr = 32'h0000_1040; cpuReq = 1'b1; cacheHit = 1'b1;
    step();
    cpuReq = 1'b0;
    chk("hitRead", DMread, 1'b1);
    chk("hitAddr", cacheAddress, 32'h0000_1040);
    step();
    chk("hitReadyEarly", cpuReady, 1'b0);
    step();
    chk("hitReady", cpuReady, 1'b1);
    step();
    chk("hitReadyOff", cpuReady, 1'b0);
    chk("hitReadCycles", dmReadCnt - r0, 1);
    chk("hitNoMemReq", memReqCnt - m0, 0);
    cacheHit = 1'b0;

`ifndef REFILL_TIMEOUT_EN
    refill(32'h1234_5678, 32'd1, 0, 1'b0);
    chk("tagConst", tag, 25'h02468AC);
    refill(32'h1234_5678, 32'd1, 3, 1'b0);

    // Reset after 7 beats drops the partial block.
    cpuAddr = 32'h0000_2080; cpuReq = 1'b1;
    step();
    cpuReq = 1'b0;
    step();
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    for (int i = 0; i < 7; i++) begin
      memValid = 1'b1; memData = 32'hDEAD_0000 + 32'(i);
      step();
    end
    memValid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midRstBlock", blockData, 512'h0);
    chk("midRstMemReq", memReq, 1'b0);
    chk("midRstAddr", cacheAddress, 32'h0);
    chk("midRstTag", tag, 25'h0);
    step();
    reset = 1'b0;
    step();
    refill(32'h0000_2080, 32'h100, 0, 1'b0);

    // A request during FILL is ignored.
    refill(32'h0000_7f00, 32'hA000_0000, 1, 1'b1);
`else
    begin
      int w0;
      w0 = dmWriteCnt;
      cpuAddr = 32'h0000_3000; cpuReq = 1'b1;
      step();
      cpuReq = 1'b0;
      step();
      for (int i = 0; i < 7; i++) step();
      chk("toErrEarly", memError, 1'b0);
      step();
      chk("toErr", memError, 1'b1);
      chk("toReady", cpuReady, 1'b1);
      chk("toNoWrite", dmWriteCnt - w0, 0);
      step();
      chk("toErrOff", memError, 1'b0);
      chk("toMemReqOff", memReq, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
